btb_update_ctrl: RTL

Branch-resolution side of the BTB: accepts resolved branches from execute, detects mispredictions against the fetch-time prediction, issues a registered fetch redirect, and drains resolved outcomes through a small FIFO onto the BTB update port (`update_en` / `update_pc` / `actual_taken` / `update_target`). It sits between the execute stage and the BTB's write path. The FIFO absorbs cycles in which the BTB cannot take a write.

---
 rtl/btb_update_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/btb_update_ctrl.sv
// BTB update controller: detects mispredictions, issues a registered fetch redirect
// and queues resolved branches for the BTB write port. Optional counters: BTB_UPD_STATS_EN.
module btb_update_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_br_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    input  logic        ex_actual_taken,
    input  logic [31:0] ex_actual_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        upd_ready,
    output logic        update_en,
    output logic [29:0] update_pc,
    output logic        actual_taken,
    output logic [31:0] update_target
`ifdef BTB_UPD_STATS_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] mp_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          redirect_valid_q, redirect_valid_d;
    logic [31:0]   redirect_pc_q, redirect_pc_d;

    logic [29:0]   pc_mem_q  [DEPTH];
    logic          tk_mem_q  [DEPTH];
    logic [31:0]   tgt_mem_q [DEPTH];

    logic full, empty, accept, mp, pop;
    logic unused_pc_lsb;

    assign unused_pc_lsb = ^ex_pc[1:0];

    always_comb begin
        full   = (count_q == DEPTH_C);
        empty  = (count_q == '0);
        accept = ex_br_valid && !full;
        mp     = (ex_actual_taken != ex_pred_taken) ||
                 (ex_actual_taken && (ex_pred_target != ex_actual_target));
        pop    = !empty && upd_ready;

        wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        redirect_valid_d = accept && mp;
        redirect_pc_d    = redirect_pc_q;
        if (accept && mp) begin
            redirect_pc_d = ex_actual_taken ? ex_actual_target
                                            : ({ex_pc[31:2], 2'b00} + 32'd4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Queue storage carries no reset; validity comes from count_q alone.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_mem_q[wr_ptr_q]  <= ex_pc[31:2];
            tk_mem_q[wr_ptr_q]  <= ex_actual_taken;
            tgt_mem_q[wr_ptr_q] <= ex_actual_target;
        end
    end

    assign ex_ready       = !full;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign update_en      = !empty;
    assign update_pc      = empty ? '0   : pc_mem_q[rd_ptr_q];
    assign actual_taken   = empty ? 1'b0 : tk_mem_q[rd_ptr_q];
    assign update_target  = empty ? '0   : tgt_mem_q[rd_ptr_q];

`ifdef BTB_UPD_STATS_EN
    logic [31:0] br_count_q, mp_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q <= '0;
            mp_count_q <= '0;
        end else begin
            if (accept)       br_count_q <= br_count_q + 32'd1;
            if (accept && mp) mp_count_q <= mp_count_q + 32'd1;
        end
    end

    assign br_count = br_count_q;
    assign mp_count = mp_count_q;
`endif

endmodule
